// File: rtl/stream_unpack_keep.sv
// stream_unpack_keep: wide-to-narrow stream unpacker with byte-keep and packet-last framing.
//   Each wide input word is held in one register. It is emitted as narrow chunks, lowest byte first.
//   Chunks whose keep slice is all zero are skipped without costing a cycle.
//   otlast is placed on the final emitted chunk of a packet.
//   A zero-keep word that ends a packet is emitted as one empty beat, so that downstream still sees last.
// Ports:
//   rstn             async active-low reset
//   clk              clock, rising edge
//   itvalid/itready  input handshake; itdata (byte 0 in [7:0], sent first), itkeep, itlast
//   otvalid/otready  output handshake; otdata, otkeep (copied keep slice), otlast
module stream_unpack_keep #(
    parameter int I_DEXP = 2,
    parameter int O_DEXP = 0
) (
    input  logic                    rstn,
    input  logic                    clk,
    input  logic                    itvalid,
    output logic                    itready,
    input  logic [(8<<I_DEXP)-1:0]  itdata,
    input  logic [(1<<I_DEXP)-1:0]  itkeep,
    input  logic                    itlast,
    output logic                    otvalid,
    input  logic                    otready,
    output logic [(8<<O_DEXP)-1:0]  otdata,
    output logic [(1<<O_DEXP)-1:0]  otkeep,
    output logic                    otlast
);
    localparam int N  = (I_DEXP >= O_DEXP) ? (1 << (I_DEXP - O_DEXP)) : 1;
    localparam int OB = 1 << O_DEXP;
    localparam int OW = 8 * OB;
    localparam int IB = 1 << I_DEXP;
    localparam int IW = 8 * IB;
    // The chunk index keeps at least one bit even when N == 1; it then stays 0.
    localparam int XW = (I_DEXP > O_DEXP) ? (I_DEXP - O_DEXP) : 1;

    if (I_DEXP < O_DEXP) begin : g_bad_param
        $error("stream_unpack_keep: I_DEXP must be >= O_DEXP");
    end

    logic [IW-1:0] hdata;
    logic [IB-1:0] hkeep;
    logic          hlast;
    logic          hvalid;
    logic [XW-1:0] idx;

    logic [N-1:0]  live;
    logic          found;
    logic          more;
    logic          zlast;
    logic [XW-1:0] cur;
    logic [XW-1:0] nxt;

    always_comb begin
        live = '0;
        for (int k = 0; k < N; k++) live[k] = |hkeep[k*OB +: OB];
    end

    // The current chunk is the lowest live chunk at or above idx.
    // The next chunk is the lowest live chunk above the current one.
    // Loops run from high to low, so the last hit is the lowest index.
    always_comb begin
        found = 1'b0;
        more  = 1'b0;
        cur   = '0;
        nxt   = '0;
        for (int k = N - 1; k >= 0; k--)
            if (live[k] && k >= int'(idx)) begin
                found = 1'b1;
                cur   = XW'(k);
            end
        for (int k = N - 1; k >= 0; k--)
            if (live[k] && k > int'(cur)) begin
                more = 1'b1;
                nxt  = XW'(k);
            end
    end

    // A held word with no live bytes that closes a packet still emits one empty beat.
    assign zlast   = hvalid & hlast & ~|hkeep;
    assign otvalid = (hvalid & found) | zlast;
    assign otdata  = (hvalid & found) ? hdata[int'(cur)*OW +: OW] : '0;
    assign otkeep  = (hvalid & found) ? hkeep[int'(cur)*OB +: OB] : '0;
    assign otlast  = otvalid & hlast & ~more;
    assign itready = ~hvalid | (otvalid & otready & ~more);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hdata  <= '0;
            hkeep  <= '0;
            hlast  <= 1'b0;
            hvalid <= 1'b0;
            idx    <= '0;
        end else if (itvalid && itready) begin
            hdata  <= itdata;
            hkeep  <= itkeep;
            hlast  <= itlast;
            hvalid <= 1'b1;
            idx    <= '0;
        end else if (otvalid && otready) begin
            if (more) begin
                idx <= nxt;
            end else begin
                hvalid <= 1'b0;
                idx    <= '0;
            end
        end else if (hvalid && !otvalid) begin
            // A zero-keep word that does not end a packet is dropped silently.
            hvalid <= 1'b0;
            idx    <= '0;
        end
    end
endmodule

// File: tb/tb_stream_unpack_keep.sv
// tb_stream_unpack_keep: directed and scoreboarded checks of stream_unpack_keep (4B->1B and 2B->2B)
module tb_stream_unpack_keep;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic        a_itvalid = 1'b0, a_itready, a_itlast = 1'b0;
    logic        a_otvalid, a_otready = 1'b1, a_otlast;
    logic [31:0] a_itdata = '0;
    logic [3:0]  a_itkeep = '0;
    logic [7:0]  a_otdata;
    logic [0:0]  a_otkeep;

    logic        b_itvalid = 1'b0, b_itready, b_itlast = 1'b0;
    logic        b_otvalid, b_otready = 1'b1, b_otlast;
    logic [15:0] b_itdata = '0;
    logic [1:0]  b_itkeep = '0;
    logic [15:0] b_otdata;
    logic [1:0]  b_otkeep;

    stream_unpack_keep #(.I_DEXP(2), .O_DEXP(0)) dut_a (
        .rstn(rstn), .clk(clk),
        .itvalid(a_itvalid), .itready(a_itready), .itdata(a_itdata), .itkeep(a_itkeep), .itlast(a_itlast),
        .otvalid(a_otvalid), .otready(a_otready), .otdata(a_otdata), .otkeep(a_otkeep), .otlast(a_otlast)
    );

    stream_unpack_keep #(.I_DEXP(1), .O_DEXP(1)) dut_b (
        .rstn(rstn), .clk(clk),
        .itvalid(b_itvalid), .itready(b_itready), .itdata(b_itdata), .itkeep(b_itkeep), .itlast(b_itlast),
        .otvalid(b_otvalid), .otready(b_otready), .otdata(b_otdata), .otkeep(b_otkeep), .otlast(b_otlast)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic exp_a(input string tag, input logic v, input logic [7:0] d, input logic k,
                         input logic l, input logic r);
        chk({tag, " otvalid"}, 32'(a_otvalid), 32'(v));
        chk({tag, " otdata"},  32'(a_otdata),  32'(d));
        chk({tag, " otkeep"},  32'(a_otkeep),  32'(k));
        chk({tag, " otlast"},  32'(a_otlast),  32'(l));
        chk({tag, " itready"}, 32'(a_itready), 32'(r));
    endtask

    task automatic send_a(input string tag, input logic [31:0] d, input logic [3:0] k, input logic l);
        a_itvalid = 1'b1;
        a_itdata  = d;
        a_itkeep  = k;
        a_itlast  = l;
        #1;
        chk({tag, " accept"}, 32'(a_itready), 32'd1);
        tick;
        a_itvalid = 1'b0;
    endtask

    task automatic exp_b(input string tag, input logic v, input logic [15:0] d, input logic [1:0] k,
                         input logic l);
        chk({tag, " otvalid"}, 32'(b_otvalid), 32'(v));
        chk({tag, " otdata"},  32'(b_otdata),  32'(d));
        chk({tag, " otkeep"},  32'(b_otkeep),  32'(k));
        chk({tag, " otlast"},  32'(b_otlast),  32'(l));
    endtask

    logic [7:0]  t1b[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0]  t6b[4] = '{8'h55, 8'h66, 8'h77, 8'h88};
    logic [15:0] t5d[4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    logic [1:0]  t5k[4] = '{2'b11, 2'b01, 2'b10, 2'b00};
    logic        t5l[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] t5o[4] = '{16'h1111, 16'h2222, 16'h3333, 16'h0000};

    logic [9:0]  q[$];
    logic [9:0]  snap;
    logic        pending, stall, fire_in;
    int          words_left, cyc;

    // Generates one random word, drives it, and queues the beats it should produce.
    task automatic new_word;
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        d = $urandom;
        k = ($urandom % 6 == 0) ? 4'h0 : 4'($urandom);
        l = ($urandom % 3 == 0) || (words_left == 1);
        for (int i = 0; i < 4; i++)
            if (k[i]) q.push_back({1'b1, l && ((k >> (i + 1)) == 4'h0), d[8*i +: 8]});
        if (k == 4'h0 && l) q.push_back({1'b0, 1'b1, 8'h00});
        a_itdata  = d;
        a_itkeep  = k;
        a_itlast  = l;
        words_left--;
        pending = 1'b1;
    endtask

    initial begin
        tick;
        exp_a("reset a", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        exp_b("reset b", 1'b0, 16'h0, 2'b00, 1'b0);
        chk("reset b itready", 32'(b_itready), 32'd1);
        rstn = 1'b1;
        tick;

        send_a("t1", 32'h44332211, 4'hF, 1'b1);
        for (int k = 0; k < 4; k++) begin
            exp_a($sformatf("t1 beat%0d", k), 1'b1, t1b[k], 1'b1, k == 3, k == 3);
            tick;
        end
        exp_a("t1 idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        send_a("t2", 32'hDDCCBBAA, 4'b1010, 1'b1);
        exp_a("t2 bb", 1'b1, 8'hBB, 1'b1, 1'b0, 1'b0);
        tick;
        exp_a("t2 dd", 1'b1, 8'hDD, 1'b1, 1'b1, 1'b1);
        tick;
        exp_a("t2 idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        send_a("t3a", 32'h5A5A5A5A, 4'h0, 1'b0);
        exp_a("t3a drop", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick;
        exp_a("t3a idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        send_a("t3b", 32'hA5A5A5A5, 4'h0, 1'b1);
        exp_a("t3b empty", 1'b1, 8'h00, 1'b0, 1'b1, 1'b1);
        tick;
        exp_a("t3b idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        send_a("t6", 32'h44332211, 4'hF, 1'b0);
        exp_a("t6 beat0", 1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
        tick;
        exp_a("t6 beat1", 1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
        tick;
        rstn = 1'b0;
        #1;
        exp_a("t6 in reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        tick;
        rstn = 1'b1;
        tick;
        exp_a("t6 after reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        send_a("t6 next", 32'h88776655, 4'hF, 1'b1);
        for (int k = 0; k < 4; k++) begin
            exp_a($sformatf("t6 next beat%0d", k), 1'b1, t6b[k], 1'b1, k == 3, k == 3);
            tick;
        end

        for (int i = 0; i < 4; i++) begin
            b_itvalid = 1'b1;
            b_itdata  = t5d[i];
            b_itkeep  = t5k[i];
            b_itlast  = t5l[i];
            #1;
            chk($sformatf("t5 itready%0d", i), 32'(b_itready), 32'd1);
            if (i == 0) chk("t5 latency", 32'(b_otvalid), 32'd0);
            else exp_b($sformatf("t5 out%0d", i - 1), 1'b1, t5o[i-1], t5k[i-1], t5l[i-1]);
            tick;
        end
        b_itvalid = 1'b0;
        exp_b("t5 out3", 1'b1, t5o[3], t5k[3], t5l[3]);
        tick;
        chk("t5 idle", 32'(b_otvalid), 32'd0);

        words_left = 400;
        cyc = 0;
        stall = 1'b0;
        pending = 1'b0;
        new_word;
        a_itvalid = pending;
        while ((pending || q.size() > 0) && cyc < 20000) begin
            a_otready = 1'($urandom % 2);
            #1;
            if (stall)
                chk("rnd stable", 32'({a_otvalid, a_otkeep, a_otlast, a_otdata}), 32'({1'b1, snap}));
            stall = a_otvalid && !a_otready;
            snap  = {a_otkeep, a_otlast, a_otdata};
            if (a_otvalid && a_otready) begin
                if (q.size() == 0) chk("rnd extra beat", 32'd1, 32'd0);
                else chk("rnd beat", 32'({a_otkeep, a_otlast, a_otdata}), 32'(q.pop_front()));
            end
            fire_in = a_itvalid && a_itready;
            tick;
            if (fire_in) begin
                pending = 1'b0;
                if (words_left > 0) new_word;
                a_itvalid = pending;
            end
            cyc++;
        end
        chk("rnd in budget", 32'(cyc < 20000), 32'd1);
        chk("rnd drained", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
